binary_decoder_pipe: RTL
========================

// Module: binary_decoder_pipe
// PURPOSE
//  Registered 4-to-16 binary decoder, the inverse of the team's 16-to-4 encoder: converts a binary code plus
//  enable into a one-hot word. Sits on a valid/ready stream between a code producer and one-hot consumers
//  (select lines, grant vectors). Buffers two entries so it sustains one decode per clock under backpressure.
// PARAMETERS
//  IN_W   4   width of binary_in
//  OUT_W  16  width of decoder_out; valid range OUT_W <= 2**IN_W
//  CNT_W  8   width of xfer_count
// PORTS
//  clk          in   1      rising-edge clock, the only clock
//  rst_n        in   1      asynchronous reset, active-low
//  in_valid     in   1      producer has a code on binary_in/enable
//  in_ready     out  1      block can accept; registered
//  enable       in   1      decode enable, sampled with binary_in
//  binary_in    in   IN_W   binary code to decode
//  out_valid    out  1      decoder_out/out_err hold a valid result
//  out_ready    in   1      consumer takes the result
//  decoder_out  out  OUT_W  one-hot result, or all zeros
//  out_err      out  1      code was out of range (binary_in >= OUT_W with enable=1)
//  xfer_count   out  CNT_W  number of accepted inputs, modulo 2**CNT_W
// BEHAVIOUR
//  - Reset (async assert, sync release): buffer empty, in_ready=1, out_valid=0, decoder_out=0, out_err=0,
//    xfer_count=0. Reset mid-operation discards all buffered entries; nothing is replayed after release.
//  - Accept on an edge where in_valid & in_ready. Transfer out on an edge where out_valid & out_ready.
//  - Decode happens at accept; the buffer stores {out_err, decoder_out}:
//    enable=0 -> out=0, err=0; enable=1 & code<OUT_W -> out=1<<code, err=0;
//    enable=1 & code>=OUT_W -> out=0, err=1.
//  - Latency: an input accepted at edge k is presented with out_valid=1 right after edge k; there is no
//    combinational path from in_* to out_*.
//  - Buffer: 2-entry FIFO, occupancy 0..2. out_valid = (occ!=0) and shows the head entry.
//    in_ready = (occ_next < 2), registered.
//  - Simultaneous push and pop at occ=1: occ stays 1 and the new entry becomes the head after the edge.
//    At occ=2: in_ready=0, so there is no push; a pop gives occ=1 and in_ready=1 after that edge.
//    Pop at occ=0 is impossible because out_valid=0.
//  - Stability: while out_valid & !out_ready, decoder_out and out_err must not change.
//  - in_valid with in_ready=0: no state change and xfer_count does not increment.
//  - xfer_count increments by 1 per accept and wraps from 2**CNT_W-1 to 0.
//  - Order: outputs leave strictly in accept order; no drop, no duplication.
// STRUCTURE
//  - Shared package decoder_pkg: default IN_W/OUT_W, typedef for the stored entry {err, onehot},
//    function onehot_decode(code, en) -> entry.
//  - Sub-module decoder_fifo2: generic 2-entry valid/ready FIFO with registered ready
//    (width parameter, occupancy counter, head/tail pointers).
//  - Top: decode function on the input path, push into decoder_fifo2, xfer_count register.
// TESTING
//  1. Reset, then stream codes 0..15 with enable=1 and out_ready=1 -> decoder_out = 0x0001, 0x0002, ...,
//     0x8000 on consecutive cycles; out_err=0; xfer_count=16; one result per clock.
//  2. enable=0 with code 5 -> decoder_out=0x0000, out_err=0, out_valid=1 for one transfer.
//  3. OUT_W=10 build, code 12 with enable=1 -> decoder_out=0, out_err=1; code 9 -> 0x200, out_err=0.
//  4. out_ready=0, push codes 3,7,1 -> codes 3 and 7 accepted, in_ready=0 on the third, output holds 0x0008.
//     Release out_ready -> 0x0008, 0x0080, 0x0002 in order.
//  5. Occ=1 with push and pop on the same edge (codes 2 then 4) -> 0x0004 then 0x0010, occ stays 1, no bubble.
//  6. Assert rst_n=0 with 2 entries buffered -> out_valid=0, in_ready=1 and xfer_count=0 immediately
//     (async); after release the first new code 6 -> 0x0040.
//  7. CNT_W=2, 5 accepts -> xfer_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths, stored-entry type and the one-hot decode rule
//   DEF_IN_W / DEF_OUT_W : default code and one-hot widths
//   entry_t              : {err, onehot}, sized for the widest supported one-hot word
//   onehot_decode        : code + enable -> entry_t, flagging codes >= out_w as errors
package decoder_pkg;
   localparam int DEF_IN_W  = 4;
   localparam int DEF_OUT_W = 16;
   localparam int MAX_OUT_W = 64;
   typedef struct packed {
      logic                 err;
      logic [MAX_OUT_W-1:0] onehot;
   } entry_t;
   function automatic entry_t onehot_decode(input logic [31:0] code, input logic en, input int out_w);
      entry_t e;
      e.err    = en && (code >= 32'(out_w));
      e.onehot = (en && (code < 32'(out_w))) ? (MAX_OUT_W'(1) << code) : '0;
      return e;
   endfunction
endpackage

// File: rtl/decoder_fifo2.sv
// decoder_fifo2: generic 2-entry valid/ready FIFO with registered in_ready
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : push handshake, in_data pushed when both high
//   out_valid/out_ready : pop handshake, out_data is the head entry
module decoder_fifo2 #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         head_q, head_d;
   logic         tail_q, tail_d;
   logic [1:0]   occ_q, occ_d;
   logic         ready_q, ready_d;
   logic         push, pop;

   always_comb begin
      push  = in_valid & ready_q;
      pop   = out_ready & (occ_q != 2'd0);
      mem_d = mem_q;
      if (push) mem_d[tail_q] = in_data;
      head_d  = pop ? ~head_q : head_q;
      tail_d  = push ? ~tail_q : tail_q;
      occ_d   = occ_q + {1'b0, push} - {1'b0, pop};
      // ready is registered from the next occupancy so it never depends on in_valid combinationally
      ready_d = occ_d < 2'd2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '{default: '0};
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         occ_q   <= 2'd0;
         ready_q <= 1'b1;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         occ_q   <= occ_d;
         ready_q <= ready_d;
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = occ_q != 2'd0;
   assign out_data  = mem_q[head_q];
endmodule

// File: rtl/binary_decoder_pipe.sv
// binary_decoder_pipe: registered binary-to-one-hot decoder on a valid/ready stream
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake carrying enable + binary_in
//   out_valid/out_ready   : output handshake carrying decoder_out + out_err
//   xfer_count            : accepted inputs modulo 2**CNT_W
module binary_decoder_pipe
   import decoder_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             enable,
   input  logic [IN_W-1:0]  binary_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] decoder_out,
   output logic             out_err,
   output logic [CNT_W-1:0] xfer_count
);
   entry_t           dec;
   logic [OUT_W:0]   push_data, pop_data;
   logic [CNT_W-1:0] xfer_count_d, xfer_count_q;
   logic             unused_hi;

   // decode at accept so the FIFO only ever stores finished results
   always_comb begin
      dec          = onehot_decode(32'(binary_in), enable, OUT_W);
      push_data    = {dec.err, dec.onehot[OUT_W-1:0]};
      xfer_count_d = (in_valid & in_ready) ? xfer_count_q + CNT_W'(1) : xfer_count_q;
   end

   // bits above OUT_W are always zero because codes >= OUT_W decode to an error
   generate
      if (OUT_W < MAX_OUT_W) begin : g_hi
         assign unused_hi = ^dec.onehot[MAX_OUT_W-1:OUT_W];
      end else begin : g_nohi
         assign unused_hi = 1'b0;
      end
   endgenerate

   decoder_fifo2 #(.W(OUT_W + 1)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (push_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (pop_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) xfer_count_q <= '0;
      else        xfer_count_q <= xfer_count_d;
   end

   assign {out_err, decoder_out} = pop_data;
   assign xfer_count             = xfer_count_q;
endmodule
